// File: rtl/msrv32_pkg.sv
// msrv32_pkg: store sizes, store-unit FSM encoding and default bus timeout
package msrv32_pkg;
  localparam logic [1:0] SIZE_SB  = 2'b00;
  localparam logic [1:0] SIZE_SH  = 2'b01;
  localparam logic [1:0] SIZE_SW  = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;
  localparam int TIMEOUT_DEFAULT = 16;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_REQ = 2'b01, ST_ERR = 2'b10} state_t;
endpackage

// File: rtl/msrv32_store_fmt.sv
// msrv32_store_fmt: replicates store data across byte lanes and builds the byte-enable mask
import msrv32_pkg::*;
module msrv32_store_fmt (
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] rs2,
  output logic [31:0] data,
  output logic [3:0]  mask
);
  assign data = size == SIZE_SB ? {4{rs2[7:0]}} : size == SIZE_SH ? {2{rs2[15:0]}} : rs2;
  assign mask = size == SIZE_SB ? 4'b0001 << offset :
                size == SIZE_SH ? (offset[1] ? 4'b1100 : 4'b0011) :
                size == SIZE_SW ? 4'b1111 : 4'b0000;
endmodule

// File: rtl/msrv32_store_unit.sv
// msrv32_store_unit: single-outstanding data-memory write port with timeout and bus-error reporting
import msrv32_pkg::*;
module msrv32_store_unit #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = 5
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        mem_wr_req_in,
  input  logic        trap_taken_in,
  input  logic [1:0]  funct3_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        ms_riscv32_mp_dmwr_ready_in,
  input  logic        ms_riscv32_mp_dmwr_err_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic        stall_out,
  output logic        store_err_out,
  output logic [31:0] store_err_addr_out
);
  state_t           state;
  logic [CNT_W-1:0] count;
  logic [31:0]      byte_addr, fmt_data;
  logic [3:0]       fmt_mask;
  logic             accept, timeout, done, fail;
  assign accept  = state == ST_IDLE && mem_wr_req_in && !trap_taken_in && funct3_in != SIZE_RSV;
  assign timeout = count == CNT_W'(TIMEOUT_CYCLES - 1);
  assign done    = ms_riscv32_mp_dmwr_ready_in || timeout;
  assign fail    = ms_riscv32_mp_dmwr_ready_in ? ms_riscv32_mp_dmwr_err_in : timeout;
  assign stall_out = accept || (state == ST_REQ && !ms_riscv32_mp_dmwr_ready_in) || state == ST_ERR;
  msrv32_store_fmt u_fmt (
    .size   (funct3_in),
    .offset (iadder_in[1:0]),
    .rs2    (rs2_in),
    .data   (fmt_data),
    .mask   (fmt_mask)
  );
  // Write FSM: registers the formatted request at accept, freezes it in REQ, pulses the error in ERR
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in)
    if (!ms_riscv32_mp_rst_n_in) begin
      state                       <= ST_IDLE;
      count                       <= '0;
      byte_addr                   <= '0;
      ms_riscv32_mp_dmaddr_out    <= '0;
      ms_riscv32_mp_dmdata_out    <= '0;
      ms_riscv32_mp_dmwr_mask_out <= '0;
      ms_riscv32_mp_dmwr_req_out  <= 1'b0;
      store_err_out               <= 1'b0;
      store_err_addr_out          <= '0;
    end else begin
      store_err_out <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          state                       <= ST_REQ;
          count                       <= '0;
          byte_addr                   <= iadder_in;
          ms_riscv32_mp_dmaddr_out    <= {iadder_in[31:2], 2'b00};
          ms_riscv32_mp_dmdata_out    <= fmt_data;
          ms_riscv32_mp_dmwr_mask_out <= fmt_mask;
          ms_riscv32_mp_dmwr_req_out  <= 1'b1;
        end
        ST_REQ: if (done) begin
          state                       <= fail ? ST_ERR : ST_IDLE;
          ms_riscv32_mp_dmwr_mask_out <= '0;
          ms_riscv32_mp_dmwr_req_out  <= 1'b0;
          store_err_out               <= fail;
          if (fail) store_err_addr_out <= byte_addr;
        end else count <= count + 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
endmodule
